// File: rtl/stim_nco.sv
// stim_nco: multi-channel square/triangle stimulus NCO with single-shot or continuous bursts.
// Defining STIM_AMPL_EN adds a per-channel amplitude scale (cfg_ampl) behind one extra register stage.
module stim_nco #(
    parameter int CH = 2,
    parameter int PW = 24,
    parameter int OW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_ch,
    input  logic [PW-1:0]    cfg_fword,
    input  logic [PW-1:0]    cfg_phase,
    input  logic             cfg_mode,
`ifdef STIM_AMPL_EN
    input  logic [OW-1:0]    cfg_ampl,
`endif
    input  logic             run,
    input  logic             stop,
    input  logic [15:0]      burst_len,
    output logic             sample_valid,
    output logic [CH*OW-1:0] sample_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [OW-1:0] POS_FULL = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] NEG_FULL = {1'b1, {(OW-1){1'b0}}};

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] blen_q;
    logic        alive_q;
    logic        vld1_q;
    logic        run_ok;
    logic        last_smp;

    assign run_ok    = run && !stop;
    assign last_smp  = (blen_q != 16'd0) && (cnt_q == blen_q - 16'd1);
    // alive_q keeps cfg_ready low while reset is held and for no longer.
    assign cfg_ready = alive_q && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (run_ok) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (stop || last_smp) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            blen_q  <= '0;
            alive_q <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            vld1_q  <= (state_q == S_RUN);
            if (state_q == S_IDLE && run_ok) begin
                blen_q <= burst_len;
            end
            if (state_q == S_LOAD) begin
                cnt_q <= '0;
            end else if (state_q == S_RUN) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

`ifdef STIM_AMPL_EN
    logic vld2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld2_q <= 1'b0;
        end else begin
            vld2_q <= vld1_q;
        end
    end

    assign sample_valid = vld2_q;
`else
    assign sample_valid = vld1_q;
`endif

    genvar gi;
    for (gi = 0; gi < CH; gi++) begin : g_ch
        logic [PW-1:0] fword_q;
        logic [PW-1:0] phase_q;
        logic [PW-1:0] acc_q;
        logic          mode_q;
        logic [OW-1:0] u;
        logic [OW-1:0] raw_d;
        logic [OW-1:0] raw_q;
        logic          cfg_hit;

        assign cfg_hit = cfg_valid && cfg_ready && (cfg_ch == 3'(gi));
        assign u       = acc_q[PW-2 -: OW];

        always_comb begin
            raw_d = '0;
            if (!mode_q) begin
                raw_d = acc_q[PW-1] ? NEG_FULL : POS_FULL;
            end else begin
                raw_d = acc_q[PW-1] ? (POS_FULL - u) : (u - NEG_FULL);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fword_q <= '0;
                phase_q <= '0;
                mode_q  <= 1'b0;
                acc_q   <= '0;
                raw_q   <= '0;
            end else begin
                if (cfg_hit) begin
                    fword_q <= cfg_fword;
                    phase_q <= cfg_phase;
                    mode_q  <= cfg_mode;
                end
                if (state_q == S_LOAD) begin
                    acc_q <= phase_q;
                end else if (state_q == S_RUN) begin
                    raw_q <= raw_d;
                    acc_q <= acc_q + fword_q;
                end
            end
        end

`ifdef STIM_AMPL_EN
        logic [OW-1:0]        ampl_q;
        logic [OW-1:0]        scl_q;
        logic signed [2*OW:0] prod;

        // ampl is unsigned, so it gets a zero sign bit before the signed multiply.
        assign prod = (2*OW+1)'($signed(raw_q)) * (2*OW+1)'($signed({1'b0, ampl_q}));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ampl_q <= '1;
                scl_q  <= '0;
            end else begin
                if (cfg_hit) begin
                    ampl_q <= cfg_ampl;
                end
                if (vld1_q) begin
                    scl_q <= OW'(prod >>> (OW-1));
                end
            end
        end

        assign sample_data[gi*OW +: OW] = scl_q;
`else
        assign sample_data[gi*OW +: OW] = raw_q;
`endif
    end

endmodule

// File: tb/tb_stim_nco.sv
// Self-checking bench for stim_nco: phase-indexed sample model plus directed burst/stop/reset scenarios.
`timescale 1ns/1ps
module tb_stim_nco;
    localparam int CH = 2;
    localparam int PW = 24;
    localparam int OW = 12;
`ifdef STIM_AMPL_EN
    localparam int LAT    = 2;
    localparam int SQ_HI  = 1023;
    localparam int SQ_LO  = -1024;
    localparam int RST_HI = -3;
`else
    localparam int LAT    = 1;
    localparam int SQ_HI  = 2047;
    localparam int SQ_LO  = -2048;
    localparam int RST_HI = 2047;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [2:0]       cfg_ch = '0;
    logic [PW-1:0]    cfg_fword = '0;
    logic [PW-1:0]    cfg_phase = '0;
    logic             cfg_mode = 1'b0;
`ifdef STIM_AMPL_EN
    logic [OW-1:0]    cfg_ampl = '0;
`endif
    logic             run = 1'b0;
    logic             stop = 1'b0;
    logic [15:0]      burst_len = '0;
    logic             sample_valid;
    logic [CH*OW-1:0] sample_data;
    logic             busy;
    logic             done;

    stim_nco #(.CH(CH), .PW(PW), .OW(OW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_fword    (cfg_fword),
        .cfg_phase    (cfg_phase),
        .cfg_mode     (cfg_mode),
`ifdef STIM_AMPL_EN
        .cfg_ampl     (cfg_ampl),
`endif
        .run          (run),
        .stop         (stop),
        .burst_len    (burst_len),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: the configuration each channel should hold.
    logic [PW-1:0] m_fword [CH];
    logic [PW-1:0] m_phase [CH];
    logic          m_mode  [CH];
    int            m_ampl  [CH];

    int n_seen = 0;
    int cap [CH][8];

    task automatic check(string name, int got, int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Sample n of a run is taken at phase + n*fword (mod 2^PW).
    function automatic int model_smp(int k, int n);
        logic [PW-1:0] a;
        logic [OW-1:0] t;
        int u;
        int v;
        a = m_phase[k] + m_fword[k] * PW'(n);
        u = int'(a[PW-2 -: OW]);
        if (!m_mode[k]) v = a[PW-1] ? -2048 : 2047;
        else            v = a[PW-1] ? (2047 - u) : (u - 2048);
`ifdef STIM_AMPL_EN
        v = (v * m_ampl[k]) >>> 11;
`endif
        t = v[OW-1:0];
        return int'($signed(t));
    endfunction

    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            for (int k = 0; k < CH; k++) begin
                int got;
                got = int'($signed(sample_data[k*OW +: OW]));
                check($sformatf("sample ch%0d n%0d", k, n_seen), got, model_smp(k, n_seen));
                if (n_seen < 8) cap[k][n_seen] = got;
            end
            n_seen++;
        end
    end

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_fword[k] = '0;
            m_phase[k] = '0;
            m_mode[k]  = 1'b0;
            m_ampl[k]  = 4095;
        end
    endtask

    task automatic cfg_write(int ch, logic [PW-1:0] fw, logic [PW-1:0] ph, logic md, int am);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_fword = fw;
        cfg_phase = ph;
        cfg_mode  = md;
`ifdef STIM_AMPL_EN
        cfg_ampl  = 12'(am);
`endif
        check("cfg_ready idle", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        if (ch < CH) begin
            m_fword[ch] = fw;
            m_phase[ch] = ph;
            m_mode[ch]  = md;
            m_ampl[ch]  = am;
        end
    endtask

    // One run of nrun RUN cycles; stop_at>0 raises stop in that RUN cycle, poke tries
    // a config write and a second run while busy.
    task automatic run_seq(int blen, int nrun, int stop_at, bit poke);
        bit exp_busy;
        bit exp_v;
        n_seen    = 0;
        run       = 1'b1;
        stop      = 1'b0;
        burst_len = 16'(blen);
        @(negedge clk);
        run       = 1'b0;
        burst_len = 16'(blen) ^ 16'h0003;
        for (int j = 0; j <= nrun + LAT + 1; j++) begin
            if (j > 0) @(negedge clk);
            exp_busy = (j <= nrun + 1);
            exp_v    = (j >= LAT + 1) && (j <= nrun + LAT);
            check($sformatf("valid j%0d", j), int'(sample_valid), int'(exp_v));
            check($sformatf("done j%0d", j), int'(done), int'(j == nrun + 1));
            check($sformatf("busy j%0d", j), int'(busy), int'(exp_busy));
            check($sformatf("cfg_ready j%0d", j), int'(cfg_ready), int'(!exp_busy));
            stop      = (stop_at > 0) && (j == stop_at);
            cfg_valid = poke && (j == 1);
            run       = poke && (j == 1);
            cfg_ch    = 3'd0;
            cfg_fword = 24'h123456;
            cfg_phase = 24'h654321;
            cfg_mode  = ~m_mode[0];
        end
        stop      = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        check("sample count", n_seen, nrun);
        $display("run blen=%0d stop_at=%0d samples=%0d", blen, stop_at, n_seen);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst valid", int'(sample_valid), 0);
        check("rst data", int'(sample_data), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst cfg_ready", int'(cfg_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("cfg_ready after release", int'(cfg_ready), 1);

        // Basic square / triangle burst
        cfg_write(0, 24'h400000, 24'h000000, 1'b0, 12'h400);
        cfg_write(1, 24'h400000, 24'h000000, 1'b1, 12'h800);
        run_seq(4, 4, 0, 1'b0);
        check("lit sq n0", cap[0][0], SQ_HI);
        check("lit sq n1", cap[0][1], SQ_HI);
        check("lit sq n2", cap[0][2], SQ_LO);
        check("lit sq n3", cap[0][3], SQ_LO);
        check("lit tri n0", cap[1][0], -2048);
        check("lit tri n1", cap[1][1], 0);
        check("lit tri n2", cap[1][2], 2047);
        check("lit tri n3", cap[1][3], -1);

        // Phase offset on ch0; out-of-range channel write is ignored
        cfg_write(0, 24'h400000, 24'h800000, 1'b0, 12'h400);
        cfg_write(5, 24'hABCDEF, 24'h7FFFFF, 1'b1, 12'h001);
        run_seq(3, 3, 0, 1'b0);
        check("lit phase ch0 n0", cap[0][0], SQ_LO);
        check("lit ch1 indep n0", cap[1][0], -2048);

        // Config write and run while busy have no effect
        run_seq(5, 5, 0, 1'b1);
        run_seq(2, 2, 0, 1'b0);
        check("lit cfg kept n0", cap[0][0], SQ_LO);

        // run and stop together in IDLE are ignored
        run  = 1'b1;
        stop = 1'b1;
        repeat (3) @(negedge clk);
        check("run+stop busy", int'(busy), 0);
        check("run+stop cfg_ready", int'(cfg_ready), 1);
        run  = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check("run+stop valid", int'(sample_valid), 0);
        check("run+stop busy2", int'(busy), 0);

        // Irregular increments and offsets
        cfg_write(0, 24'h012345, 24'h3FFFFF, 1'b1, 12'hFFF);
        cfg_write(1, 24'h0F0F0F, 24'h100000, 1'b0, 12'h7FF);
        run_seq(20, 20, 0, 1'b0);

        // Continuous run past counter wrap, ended by stop
        run_seq(0, 70000, 70000, 1'b0);

        // Reset in the middle of a continuous run
        n_seen    = 0;
        run       = 1'b1;
        burst_len = 16'd0;
        @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst valid", int'(sample_valid), 0);
        check("midrst data", int'(sample_data), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst cfg_ready", int'(cfg_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst no done", int'(done), 0);
        end
        rst_n = 1'b1;
        model_reset();
        $display("reset mid-run released");
        @(negedge clk);
        check("post rst cfg_ready", int'(cfg_ready), 1);
        check("post rst done", int'(done), 0);
        run_seq(3, 3, 0, 1'b0);
        check("lit cleared cfg n0", cap[0][0], RST_HI);
        check("lit cleared cfg n2", cap[1][2], RST_HI);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stim_nco.md
STIM_NCO -- requirements
Module: stim_nco

Interface
REQ-001 SHALL have parameter CH, default 2, number of independent stimulus channels (1..8).
REQ-002 SHALL have parameter PW, default 24, phase accumulator width.
REQ-003 SHALL have parameter OW, default 12, signed sample width per channel.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: cfg_valid  input  1  configuration write request.
REQ-008 SHALL have port: cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-009 SHALL have port: cfg_ch  input  3  target channel index; writes to index >= CH are ignored.
REQ-010 SHALL have port: cfg_fword  input  PW  phase increment per sample.
REQ-011 SHALL have port: cfg_phase  input  PW  start phase offset.
REQ-012 SHALL have port: cfg_mode  input  1  waveform, 0 = square, 1 = triangle.
REQ-013 SHALL have port: cfg_ampl  input  OW  unsigned amplitude scale; present only with STIM_AMPL_EN.
REQ-014 SHALL have port: run  input  1  start pulse.
REQ-015 SHALL have port: stop  input  1  abort request.
REQ-016 SHALL have port: burst_len  input  16  samples per run, 0 = continuous; sampled on accepted run.
REQ-017 SHALL have port: sample_valid  output  1  sample_data valid this cycle.
REQ-018 SHALL have port: sample_data  output  CH*OW  channel k in bits [k*OW +: OW], two's complement.
REQ-019 SHALL have port: busy  output  1  high in LOAD, RUN or DONE.
REQ-020 SHALL have port: done  output  1  one-cycle pulse at end of run.

Function
REQ-021 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-022 cfg_ready SHALL equal (state == IDLE); a handshake writes fword/phase/mode/ampl of cfg_ch in that cycle.
REQ-023 IDLE -> LOAD on run=1 and stop=0; run and stop together in IDLE SHALL be ignored.
REQ-024 LOAD (one cycle) SHALL set each channel accumulator to its cfg_phase and the burst counter to 0.
REQ-025 Each RUN cycle SHALL register a sample from the current accumulator, then add fword modulo 2^PW, and increment the burst counter.
REQ-026 sample_valid SHALL assert one cycle after each RUN cycle (latency 1), two cycles with STIM_AMPL_EN.
REQ-027 Square: accumulator MSB=0 -> +(2^(OW-1)-1), MSB=1 -> -2^(OW-1).
REQ-028 Triangle: u = acc[PW-2 -: OW]; MSB=0 -> u - 2^(OW-1); MSB=1 -> (2^(OW-1)-1) - u.
REQ-029 RUN -> DONE after the RUN cycle where counter == burst_len-1 (burst_len != 0), or on stop=1; the counter wraps silently when burst_len=0.
REQ-030 DONE SHALL last one cycle, assert done, then go to IDLE; in-flight pipeline samples still emit sample_valid.
REQ-031 run during LOAD/RUN/DONE SHALL be ignored; cfg_valid outside IDLE SHALL not write.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, clear all accumulators, config registers (fword, phase, mode=0, ampl=2^OW-1), counter and pipeline.
REQ-033 During reset, sample_valid=0, sample_data=0, busy=0, done=0, cfg_ready=0; cfg_ready=1 from the first clock after release.
REQ-034 Reset mid-RUN SHALL discard pending samples without a done pulse.

Configuration
REQ-035 With macro STIM_AMPL_EN defined, the block SHALL output (raw * ampl) arithmetic-shifted right by OW-1 through one extra register stage, and cfg_ampl SHALL exist.
REQ-036 Without STIM_AMPL_EN, the block SHALL have no cfg_ampl, no multiplier and no extra stage, and output the raw sample.

Verification (CH=2, PW=24, OW=12, macro off unless stated)
REQ-037 ch0 square with fword=0x400000 and phase=0; run with burst_len=4 -> samples +2047, +2047, -2048, -2048; done 1 cycle after the last RUN cycle.
REQ-038 ch1 triangle with fword=0x400000 and phase=0 -> samples -2048, 0, 2047, -1.
REQ-039 ch0 with phase=0x800000 square -> first sample -2048; ch1 stays independent in the same run.
REQ-040 burst_len=0 -> sample_valid continuous for 70000 cycles, counter wrap; stop -> DONE next cycle, done pulse, then cfg_ready=1.
REQ-041 cfg_valid during RUN -> cfg_ready=0 and the config is unchanged on the next run; run+stop together in IDLE -> stays IDLE.
REQ-042 With STIM_AMPL_EN, ampl=0x400 and square -> +1023/-1024 at latency 2; rst_n low mid-RUN -> all outputs 0 and no done.
